// File: rtl/pixel_stream_source.sv
// pixel_stream_source: reads a stored RGB frame through a synchronous memory
// read port and emits it as a raster pixel stream with valid/ready handshake.
// Each line is preceded by HSYNC_LEN blanking cycles; rows may be emitted
// top-down or bottom-up.
//
// Ports:
//   horizontal_clock   clock, rising edge
//   horizontal_reset   asynchronous, active-low reset
//   start, bottom_up   frame request and row order (sampled in IDLE)
//   mem_rd, mem_addr   combinational memory read strobe / word address
//   mem_rdata          {r,g,b}, valid one cycle after mem_rd
//   horizontal_sync    pixel valid (output buffer non-empty)
//   out_ready          downstream accept
//   r, g, b, sol, eol  head-of-buffer pixel and line position flags
//   done, busy         frame-complete pulse and frame-in-progress flag
module pixel_stream_source #(
    parameter int unsigned WIDTH     = 384,
    parameter int unsigned HEIGHT    = 256,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned HSYNC_LEN = 160,
    parameter int unsigned ADDR_W    = 17
) (
    input  logic                 horizontal_clock,
    input  logic                 horizontal_reset,
    input  logic                 start,
    input  logic                 bottom_up,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [3*PIX_W-1:0]   mem_rdata,
    output logic                 horizontal_sync,
    input  logic                 out_ready,
    output logic [PIX_W-1:0]     r,
    output logic [PIX_W-1:0]     g,
    output logic [PIX_W-1:0]     b,
    output logic                 sol,
    output logic                 eol,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BLK_W = (HSYNC_LEN > 1) ? $clog2(HSYNC_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HBLANK, S_PIXEL, S_DRAIN} state_e;

    typedef struct packed {
        logic [3*PIX_W-1:0] pix;
        logic               sol;
        logic               eol;
    } entry_t;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [BLK_W-1:0]   blank_q, blank_d;
    logic               bu_q, bu_d;
    logic               inflight_q, inflight_d;
    logic               tag_sol_q, tag_sol_d;
    logic               tag_eol_q, tag_eol_d;
    entry_t             head_q, head_d;
    entry_t             tail_q, tail_d;
    logic [1:0]         count_q, count_d;
    logic               hsync_q, hsync_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               pop_c;
    logic               push_c;
    logic               rd_c;
    logic [2:0]         pending_c;
    logic [ROW_W-1:0]   src_row_c;
    entry_t             entry_in_c;

    // State and datapath registers
    always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
        if (!horizontal_reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            blank_q    <= '0;
            bu_q       <= 1'b0;
            inflight_q <= 1'b0;
            tag_sol_q  <= 1'b0;
            tag_eol_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            hsync_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            blank_q    <= blank_d;
            bu_q       <= bu_d;
            inflight_q <= inflight_d;
            tag_sol_q  <= tag_sol_d;
            tag_eol_q  <= tag_eol_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            hsync_q    <= hsync_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Read issue and address generation
    always_comb begin
        pop_c     = hsync_q & out_ready;
        push_c    = inflight_q;
        pending_c = 3'(count_q) + 3'(inflight_q);
        // At most two pixels may be buffered or in flight once this cycle's pop retires
        rd_c      = (state_q == S_PIXEL) && (pending_c < (3'd2 + 3'(pop_c)));
        src_row_c = bu_q ? (ROW_W'(HEIGHT - 1) - row_q) : row_q;
        mem_rd    = rd_c;
        mem_addr  = ADDR_W'(src_row_c) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
        entry_in_c.pix = mem_rdata;
        entry_in_c.sol = tag_sol_q;
        entry_in_c.eol = tag_eol_q;
    end

    // Next-state logic: frame FSM, 2-entry shift FIFO, status flags
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        blank_d    = blank_q;
        bu_d       = bu_q;
        inflight_d = rd_c;
        tag_sol_d  = tag_sol_q;
        tag_eol_d  = tag_eol_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        hsync_d    = hsync_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bu_d    = bottom_up;
                    row_d   = '0;
                    col_d   = '0;
                    blank_d = '0;
                    state_d = S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (blank_q == BLK_W'(HSYNC_LEN - 1)) begin
                    blank_d = '0;
                    state_d = S_PIXEL;
                end else begin
                    blank_d = blank_q + BLK_W'(1);
                end
            end
            S_PIXEL: begin
                if (rd_c) begin
                    if (col_q == COL_W'(WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(HEIGHT - 1)) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_HBLANK;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: begin
                // done is visible for one cycle while still in DRAIN
                if (done_q) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Position flags travel with the read so they line up with mem_rdata
        if (rd_c) begin
            tag_sol_d = (col_q == '0);
            tag_eol_d = (col_q == COL_W'(WIDTH - 1));
        end

        // Head register drives the outputs directly; it is zero whenever empty
        case (count_q)
            2'd0: begin
                if (push_c) head_d = entry_in_c;
            end
            2'd1: begin
                if (pop_c) begin
                    head_d = push_c ? entry_in_c : '0;
                end else if (push_c) begin
                    tail_d = entry_in_c;
                end
            end
            default: begin
                if (pop_c) begin
                    head_d = tail_q;
                    if (push_c) tail_d = entry_in_c;
                end
            end
        endcase
        count_d = count_q + 2'(push_c) - 2'(pop_c);
        hsync_d = (count_d != 2'd0);

        // Look ahead one cycle so done follows the final accept immediately
        done_d = (state_q == S_DRAIN) && !done_q && (count_d == 2'd0) && !inflight_d;
        busy_d = (state_d != S_IDLE) && !done_d;
    end

    assign horizontal_sync = hsync_q;
    assign r               = head_q.pix[3*PIX_W-1:2*PIX_W];
    assign g               = head_q.pix[2*PIX_W-1:PIX_W];
    assign b               = head_q.pix[PIX_W-1:0];
    assign sol             = head_q.sol;
    assign eol             = head_q.eol;
    assign done            = done_q;
    assign busy            = busy_q;

endmodule

// File: doc/pixel_stream_source.md
# pixel_stream_source

Parametrised image-to-pixel-stream source for the resizing pipeline. On a start request it reads a stored RGB frame through an external synchronous memory read port, inserts a programmable horizontal-sync blanking interval before every line, and emits pixels in raster order. Rows can be emitted top-down or bottom-up (BMP order). The pixel output has valid/ready backpressure, and the block adds start-of-line, end-of-line and frame-done signalling.

## Interface
- WIDTH, 384: pixels per line (≥2)
- HEIGHT, 256: lines per frame (≥1)
- PIX_W, 8: bits per colour channel
- HSYNC_LEN, 160: blanking cycles before each line (≥1)
- ADDR_W, 17: memory word-address width; must satisfy 2^ADDR_W ≥ WIDTH·HEIGHT
- horizontal_clock  in  1  clock, all logic on rising edge
- horizontal_reset  in  1  reset; asynchronous, active-low
- start  in  1  frame request; sampled only in IDLE
- bottom_up  in  1  row order, sampled with start (1 = memory row HEIGHT-1 first)
- mem_rd  out  1  read strobe (combinational)
- mem_addr  out  ADDR_W  word address = src_row·WIDTH + col (combinational)
- mem_rdata  in  3·PIX_W  {r,g,b}; valid exactly one cycle after mem_rd
- horizontal_sync  out  1  pixel valid; high while the output buffer is non-empty
- out_ready  in  1  downstream accept
- r, g, b  out  PIX_W each  head-of-buffer pixel; 0 when horizontal_sync=0
- sol, eol  out  1 each  head pixel is col 0 / col WIDTH-1; 0 when invalid
- done  out  1  one-cycle pulse after the last pixel of the frame is accepted
- busy  out  1  high from start acceptance until the cycle done is asserted

## Operation
- FSM states: IDLE, HBLANK, PIXEL, DRAIN.
- IDLE:
  - start=1 latches bottom_up, clears row/col, and moves to HBLANK.
  - start in any other state is ignored.
- HBLANK:
  - Blank counter counts 0..HSYNC_LEN-1, one per cycle, independent of out_ready.
  - At HSYNC_LEN-1, go to PIXEL.
  - The buffer may still drain the previous line during HBLANK.
- PIXEL:
  - mem_rd=1 when occupancy + inflight − pop < 2, where pop = horizontal_sync & out_ready.
  - Each read advances col.
  - The read at col=WIDTH-1 wraps col to 0 and increments row.
  - That same read moves the FSM to HBLANK if it was not the last row, else to DRAIN.
- src_row = bottom_up_latched ? HEIGHT-1-row : row. Address arithmetic is unsigned, truncated to ADDR_W.
- DRAIN: when the buffer is empty and no read is in flight, pulse done for one cycle and return to IDLE.
- Output buffer:
  - 2-entry FIFO of {pixel, sol, eol}.
  - Write and read in the same cycle are allowed.
  - It never overflows, because of the issue rule above.
- Once horizontal_sync is high, r/g/b/sol/eol must hold stable until accepted.
- frame position flags: sol is set for col 0 entries and eol for col WIDTH-1 entries, tagged at read issue.
- Reset, including mid-frame:
  - FSM → IDLE; row, col, blank counter, inflight and FIFO cleared.
  - All outputs 0: mem_rd=0, mem_addr=0, horizontal_sync=0, r=g=b=0, sol=eol=done=busy=0.
  - No done pulse is issued for an aborted frame.

## Timing
- start sampled at edge E0:
  - HBLANK occupies cycles 1..HSYNC_LEN.
  - First mem_rd occurs in cycle HSYNC_LEN+1.
  - mem_rdata arrives in cycle HSYNC_LEN+2 and is written to the FIFO at the end of that cycle.
  - horizontal_sync rises in cycle HSYNC_LEN+3.
- Read-to-valid latency is 2 cycles.
- With out_ready held at 1, throughput is 1 pixel/cycle within a line.
- Line period with out_ready=1 is HSYNC_LEN + WIDTH cycles.
- Frame with out_ready=1:
  - Last pixel is accepted in cycle HEIGHT·(HSYNC_LEN+WIDTH)+2.
  - done is asserted in the next cycle; busy falls in the same cycle as done.
- out_ready=0 stalls reads after 2 entries are buffered/in flight; no pixel is lost or duplicated.
- A start asserted in the same cycle as done is ignored (state ≠ IDLE). IDLE is reached the cycle after done.

## Test plan
- Basic frame, WIDTH=4, HEIGHT=3, HSYNC_LEN=5, bottom_up=0, memory word n = n·0x010101, out_ready=1.
  - Expect 12 pixels with r=g=b=0..11 in order.
  - horizontal_sync first high in cycle 8.
  - sol on pixels 0/4/8, eol on pixels 3/7/11.
  - Single done pulse in cycle 30.
- Same frame with bottom_up=1: pixel order 8,9,10,11,4,5,6,7,0,1,2,3; mem_addr sequence matches.
- Backpressure, with out_ready randomly 30% low:
  - Identical pixel sequence, no gaps or duplicates.
  - r/g/b stable whenever horizontal_sync=1 and out_ready=0.
  - mem_rd never issued with 2 entries pending.
- out_ready held 0 for 20 cycles mid-line:
  - Exactly 2 pixels buffered, mem_rd low.
  - Sequence resumes correctly after release.
  - Blank counter still expires 5 cycles after the line's last read.
- Async reset mid-line 2:
  - All outputs 0 immediately with no clock.
  - No done pulse.
  - A new start produces a full correct frame from pixel 0.
- start pulsed while busy, and pulsed in the done cycle: ignored. A second start in IDLE begins a new frame with a fresh HSYNC_LEN blanking.
